quad_decoder_v3: RTL and testbench

- Parametrised next-generation quadrature encoder interface.
- Synchronises and glitch-filters the A/B/index inputs, decodes in x4/x2/x1 mode, and maintains a wrapping position count with preset and index-clear.
- Flags illegal transitions and produces a windowed signed velocity.
- Sits between encoder pins and the DSP controller loop; consumers sample `count` and `velocity` on `vel_valid`.

---
 rtl/quad_decoder_v3_if.sv | 33 +++
 rtl/quad_decoder_v3.sv | 212 +++++++++++++++++++++
 tb/tb_quad_decoder_v3.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_decoder_v3_if.sv
// Pin and controller bus of the quadrature decoder.
// The decoder connects through the slave modport; the driving side uses master.
interface quad_decoder_v3_if #(
    parameter int COUNT_W = 32,
    parameter int VEL_W   = 16
);
    logic                      quadA;
    logic                      quadB;
    logic                      index;
    logic [1:0]                mode;
    logic                      dir_invert;
    logic                      preset_en;
    logic [COUNT_W-1:0]        preset_val;
    logic                      index_clr_en;
    logic                      err_clr;
    logic [COUNT_W-1:0]        count;
    logic                      dir;
    logic signed [VEL_W-1:0]   velocity;
    logic                      vel_valid;
    logic                      err;

    modport master (
        output quadA, quadB, index, mode, dir_invert, preset_en, preset_val,
               index_clr_en, err_clr,
        input  count, dir, velocity, vel_valid, err
    );

    modport slave (
        input  quadA, quadB, index, mode, dir_invert, preset_en, preset_val,
               index_clr_en, err_clr,
        output count, dir, velocity, vel_valid, err
    );
endinterface

// File: rtl/quad_decoder_v3.sv
// Quadrature encoder interface: synchroniser, glitch filter, x4/x2/x1 decode,
// wrapping position counter with preset/index clear, illegal-transition flag and windowed velocity.
module quad_decoder_v3 #(
    parameter int COUNT_W     = 32,
    parameter int VEL_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int VEL_PERIOD  = 100000
) (
    input  logic              clk,
    input  logic              rst,
    quad_decoder_v3_if.slave  bus
);
    localparam int SETTLE   = SYNC_STAGES + FILT_LEN + 1;
    localparam int SET_W    = $clog2(SETTLE + 1);
    localparam int RUN_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int WIN_W    = (VEL_PERIOD > 2) ? $clog2(VEL_PERIOD) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_PERIOD - 1);
    localparam logic signed [VEL_W:0] VEL_MAX = $signed({2'b00, {(VEL_W-1){1'b1}}});
    localparam logic signed [VEL_W:0] VEL_MIN = -VEL_MAX;

    // Symmetric saturating add of a single step to the velocity accumulator.
    function automatic logic signed [VEL_W-1:0] sat_add(
        input logic signed [VEL_W-1:0] acc,
        input logic signed [VEL_W:0]   inc
    );
        logic signed [VEL_W:0] sum;
        sum = $signed({acc[VEL_W-1], acc}) + inc;
        if (sum > VEL_MAX) begin
            sat_add = VEL_MAX[VEL_W-1:0];
        end else if (sum < VEL_MIN) begin
            sat_add = VEL_MIN[VEL_W-1:0];
        end else begin
            sat_add = sum[VEL_W-1:0];
        end
    endfunction

    logic [SYNC_STAGES-1:0]  sync_a_r;
    logic [SYNC_STAGES-1:0]  sync_b_r;
    logic [SYNC_STAGES-1:0]  sync_i_r;
    logic [1:0]              synced_s;
    logic [1:0]              filt_r;
    logic [RUN_W-1:0]        run_r [2];
    logic [1:0]              prev_r;
    logic                    idx_prev_r;
    logic [SET_W-1:0]        settle_r;
    logic                    active_s;
    logic                    a_chg_s;
    logic                    b_chg_s;
    logic                    step_s;
    logic                    up_s;
    logic                    illegal_s;
    logic                    idx_clr_s;
    logic signed [VEL_W:0]   step_ext_s;
    logic signed [VEL_W-1:0] acc_next_s;
    logic [WIN_W-1:0]        win_r;
    logic signed [VEL_W-1:0] acc_r;
    logic [COUNT_W-1:0]      count_r;
    logic                    dir_r;
    logic                    err_r;
    logic signed [VEL_W-1:0] velocity_r;
    logic                    vel_valid_r;

    // Bit 1 is channel A, bit 0 is channel B throughout the filter and decode.
    assign synced_s = {sync_a_r[SYNC_STAGES-1], sync_b_r[SYNC_STAGES-1]};
    assign active_s = (settle_r == SET_W'(SETTLE));
    assign a_chg_s  = filt_r[1] ^ prev_r[1];
    assign b_chg_s  = filt_r[0] ^ prev_r[0];

    // Metastability synchronisers for the three asynchronous pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a_r <= {SYNC_STAGES{1'b0}};
            sync_b_r <= {SYNC_STAGES{1'b0}};
            sync_i_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_a_r <= {sync_a_r[SYNC_STAGES-2:0], bus.quadA};
            sync_b_r <= {sync_b_r[SYNC_STAGES-2:0], bus.quadB};
            sync_i_r <= {sync_i_r[SYNC_STAGES-2:0], bus.index};
        end
    end

    // Per-channel run-length filter: any agreement restarts the disagreement run.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_r <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                run_r[ch] <= {RUN_W{1'b0}};
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (synced_s[ch] == filt_r[ch]) begin
                    run_r[ch] <= {RUN_W{1'b0}};
                end else if (run_r[ch] == RUN_LAST) begin
                    filt_r[ch] <= synced_s[ch];
                    run_r[ch]  <= {RUN_W{1'b0}};
                end else begin
                    run_r[ch] <= run_r[ch] + RUN_W'(1);
                end
            end
        end
    end

    // Previous-state tracking and post-reset settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r     <= 2'b00;
            idx_prev_r <= 1'b0;
            settle_r   <= {SET_W{1'b0}};
        end else begin
            prev_r     <= filt_r;
            idx_prev_r <= sync_i_r[SYNC_STAGES-1];
            if (!active_s) begin
                settle_r <= settle_r + SET_W'(1);
            end else begin
                settle_r <= settle_r;
            end
        end
    end

    // Edge decode; during settle nothing is counted or flagged.
    always_comb begin
        step_s    = 1'b0;
        up_s      = 1'b0;
        illegal_s = 1'b0;
        idx_clr_s = 1'b0;
        if (active_s) begin
            illegal_s = a_chg_s & b_chg_s;
            idx_clr_s = bus.index_clr_en & sync_i_r[SYNC_STAGES-1] & ~idx_prev_r;
            up_s      = (filt_r[1] ^ prev_r[0]) ^ bus.dir_invert;
            case (bus.mode)
                2'b01:   step_s = a_chg_s & ~b_chg_s;
                2'b10:   step_s = a_chg_s & ~b_chg_s & ~filt_r[0];
                default: step_s = a_chg_s ^ b_chg_s;
            endcase
        end else begin
            step_s    = 1'b0;
            up_s      = 1'b0;
            illegal_s = 1'b0;
            idx_clr_s = 1'b0;
        end
    end

    // Signed step value and the saturated running window sum.
    always_comb begin
        step_ext_s = {(VEL_W+1){1'b0}};
        if (step_s) begin
            step_ext_s = up_s ? {{VEL_W{1'b0}}, 1'b1} : {(VEL_W+1){1'b1}};
        end else begin
            step_ext_s = {(VEL_W+1){1'b0}};
        end
        acc_next_s = sat_add(acc_r, step_ext_s);
    end

    // Position counter, direction and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {COUNT_W{1'b0}};
            dir_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (bus.preset_en) begin
                count_r <= bus.preset_val;
            end else if (idx_clr_s) begin
                count_r <= {COUNT_W{1'b0}};
            end else if (step_s) begin
                count_r <= up_s ? count_r + COUNT_W'(1) : count_r - COUNT_W'(1);
            end else begin
                count_r <= count_r;
            end
            if (step_s) begin
                dir_r <= up_s;
            end else begin
                dir_r <= dir_r;
            end
            if (illegal_s) begin
                err_r <= 1'b1;
            end else if (bus.err_clr) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Velocity window: publish the step sum on the last window cycle and restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_r       <= {WIN_W{1'b0}};
            acc_r       <= {VEL_W{1'b0}};
            velocity_r  <= {VEL_W{1'b0}};
            vel_valid_r <= 1'b0;
        end else if (win_r == WIN_LAST) begin
            win_r       <= {WIN_W{1'b0}};
            acc_r       <= {VEL_W{1'b0}};
            velocity_r  <= acc_next_s;
            vel_valid_r <= 1'b1;
        end else begin
            win_r       <= win_r + WIN_W'(1);
            acc_r       <= acc_next_s;
            velocity_r  <= velocity_r;
            vel_valid_r <= 1'b0;
        end
    end

    assign bus.count     = count_r;
    assign bus.dir       = dir_r;
    assign bus.err       = err_r;
    assign bus.velocity  = velocity_r;
    assign bus.vel_valid = vel_valid_r;
endmodule

// File: tb/tb_quad_decoder_v3.sv
// Directed plus randomized bench for quad_decoder_v3 against a Gray-position event model.
module tb_quad_decoder_v3;
    localparam int CW   = 32;
    localparam int P    = 50;
    localparam int SS   = 2;
    localparam int FL   = 3;
    localparam int LAT  = SS + FL + 1;
    localparam int ILAT = SS + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quad_decoder_v3_if #(.COUNT_W(CW), .VEL_W(16)) ifm();
    quad_decoder_v3_if #(.COUNT_W(CW), .VEL_W(4))  ifs();

    assign ifs.quadA        = ifm.quadA;
    assign ifs.quadB        = ifm.quadB;
    assign ifs.index        = ifm.index;
    assign ifs.mode         = ifm.mode;
    assign ifs.dir_invert   = ifm.dir_invert;
    assign ifs.preset_en    = ifm.preset_en;
    assign ifs.preset_val   = ifm.preset_val;
    assign ifs.index_clr_en = ifm.index_clr_en;
    assign ifs.err_clr      = ifm.err_clr;

    quad_decoder_v3 #(.COUNT_W(CW), .VEL_W(16), .SYNC_STAGES(SS), .FILT_LEN(FL), .VEL_PERIOD(P))
        dut (.clk(clk), .rst(rst), .bus(ifm));
    quad_decoder_v3 #(.COUNT_W(CW), .VEL_W(4), .SYNC_STAGES(SS), .FILT_LEN(FL), .VEL_PERIOD(P))
        dut_s (.clk(clk), .rst(rst), .bus(ifs));

    int n_cmp;
    int n_err;
    int edge_n;
    int pos;
    int ev_edge[$];
    int ev_kind[$];
    logic [CW-1:0] m_count;
    logic m_dir;
    logic m_err;
    int wsum_m, wsum_s, exp_vel_m, exp_vel_s;
    logic exp_valid;

    function automatic logic pin_a(input int p);
        return (p == 1) || (p == 2);
    endfunction

    function automatic logic pin_b(input int p);
        return (p == 2) || (p == 3);
    endfunction

    function automatic int clamp(input int v, input int lim);
        if (v > lim) return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp_v);
        end
    endtask

    task automatic check_all();
        check("count", {32'd0, ifm.count}, {32'd0, m_count});
        check("dir", {63'd0, ifm.dir}, {63'd0, m_dir});
        check("err", {63'd0, ifm.err}, {63'd0, m_err});
        check("vel_valid", {63'd0, ifm.vel_valid}, {63'd0, exp_valid});
        check("vel_valid_w4", {63'd0, ifs.vel_valid}, {63'd0, exp_valid});
        check("velocity", {48'd0, ifm.velocity}, {48'd0, 16'(exp_vel_m)});
        check("velocity_w4", {60'd0, ifs.velocity}, {60'd0, 4'(exp_vel_s)});
        check("count_w4", {32'd0, ifs.count}, {32'd0, m_count});
    endtask

    // Advance the model to what the decoder should show after this clock edge.
    task automatic model_edge();
        int delta;
        bit ill;
        bit iclr;
        delta = 0;
        ill   = 1'b0;
        iclr  = 1'b0;
        for (int i = ev_edge.size() - 1; i >= 0; i--) begin
            if (ev_edge[i] == edge_n) begin
                if (ev_kind[i] == 5) ill = 1'b1;
                else if (ev_kind[i] == 9) iclr = 1'b1;
                else delta += ev_kind[i];
                ev_edge.delete(i);
                ev_kind.delete(i);
            end
        end
        if (ifm.preset_en) m_count = ifm.preset_val;
        else if (iclr && ifm.index_clr_en) m_count = '0;
        else m_count = m_count + delta;
        if (delta != 0) m_dir = (delta > 0);
        if (ill) m_err = 1'b1;
        else if (ifm.err_clr) m_err = 1'b0;
        wsum_m = clamp(wsum_m + delta, 32767);
        wsum_s = clamp(wsum_s + delta, 7);
        if (edge_n % P == 0) begin
            exp_vel_m = wsum_m;
            exp_vel_s = wsum_s;
            exp_valid = 1'b1;
            wsum_m = 0;
            wsum_s = 0;
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input int e, input int k);
        ev_edge.push_back(e);
        ev_kind.push_back(k);
    endtask

    // One legal Gray step; the counted value follows from mode and the position table.
    task automatic move(input int d);
        int np;
        int delta;
        np = (pos + d + 4) % 4;
        case (ifm.mode)
            2'b01:   delta = (pin_a(pos) != pin_a(np)) ? d : 0;
            2'b10:   delta = (d == 1 && pos == 0) ? 1 : ((d == -1 && pos == 1) ? -1 : 0);
            default: delta = d;
        endcase
        if (ifm.dir_invert) delta = -delta;
        pos = np;
        ifm.quadA = pin_a(pos);
        ifm.quadB = pin_b(pos);
        push(edge_n + LAT, delta);
    endtask

    task automatic preset(input logic [CW-1:0] v);
        ifm.preset_val = v;
        ifm.preset_en  = 1'b1;
        tick();
        ifm.preset_en  = 1'b0;
        idle(2);
    endtask

    task automatic index_pulse();
        ifm.index = 1'b1;
        push(edge_n + ILAT, 9);
        idle(3);
        ifm.index = 1'b0;
        idle(6);
    endtask

    task automatic align_window();
        while (edge_n % P != 0) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        edge_n = 0;
        pos = 2;
        ifm.quadA = pin_a(pos);
        ifm.quadB = pin_b(pos);
        ifm.index = 1'b0;
        ifm.mode = 2'b00;
        ifm.dir_invert = 1'b0;
        ifm.preset_en = 1'b0;
        ifm.preset_val = '0;
        ifm.index_clr_en = 1'b0;
        ifm.err_clr = 1'b0;
        m_count = '0;
        m_dir = 1'b0;
        m_err = 1'b0;
        wsum_m = 0;
        wsum_s = 0;
        exp_vel_m = 0;
        exp_vel_s = 0;
        exp_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        edge_n = 0;
        idle(20);

        repeat (8) begin move(1); idle(10); end
        repeat (8) begin move(-1); idle(10); end

        ifm.mode = 2'b01;
        repeat (8) begin move(1); idle(6); end
        idle(8);
        preset('0);
        ifm.mode = 2'b10;
        repeat (8) begin move(1); idle(6); end
        idle(8);
        repeat (8) begin move(-1); idle(6); end
        idle(8);

        preset('0);
        ifm.mode = 2'b00;
        ifm.dir_invert = 1'b1;
        repeat (4) begin move(1); idle(6); end
        idle(8);
        ifm.dir_invert = 1'b0;

        ifm.quadA = ~ifm.quadA;
        idle(2);
        ifm.quadA = pin_a(pos);
        idle(10);

        pos = (pos + 2) % 4;
        ifm.quadA = pin_a(pos);
        ifm.quadB = pin_b(pos);
        push(edge_n + LAT, 5);
        idle(10);
        ifm.err_clr = 1'b1;
        tick();
        ifm.err_clr = 1'b0;
        idle(2);

        preset(32'h7FFF_FFFF);
        move(1);
        idle(8);
        ifm.index_clr_en = 1'b1;
        index_pulse();
        move(1);
        idle(8);
        ifm.index_clr_en = 1'b0;
        index_pulse();

        align_window();
        repeat (5) begin move(1); idle(6); end
        align_window();
        repeat (3) begin move(-1); idle(6); end
        align_window();
        repeat (10) begin move(1); idle(4); end
        align_window();
        idle(2);

        for (int blk = 0; blk < 6; blk++) begin
            ifm.mode = 2'($urandom_range(0, 3));
            ifm.dir_invert = 1'($urandom_range(0, 1));
            for (int k = 0; k < 14; k++) begin
                move(($urandom_range(0, 3) != 0) ? 1 : -1);
                idle($urandom_range(4, 9));
            end
            idle(10);
        end
        align_window();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
